fifo_flow_ctrl: RTL and testbench
=================================

# fifo_flow_ctrl

Parametrised synchronous FIFO with programmable almost-full/almost-empty thresholds, a flow-control pause output, a registered read path with valid strobe, and sticky overflow/underflow error reporting. It is the next-generation buffer for the data path: it generalises the fixed 6-bit FIFO in data width and depth and adds threshold-based back-pressure toward the upstream producer.

## Interface
- DATA_W, 6, data word width in bits (≥1)
- DEPTH, 4, number of entries; power of two, ≥2
- ADDR_W (localparam), log2(DEPTH), pointer width; count width is ADDR_W+1
- clk  input  1  single clock, all state on rising edge
- reset_L  input  1  asynchronous, active-low reset
- push  input  1  write request
- pop  input  1  read request
- fifo_data_in  input  DATA_W  write data, sampled with push
- almost_full_thr  input  ADDR_W+1  pause threshold; 0 disables pausa
- almost_empty_thr  input  ADDR_W+1  almost-empty threshold
- err_clr  input  1  synchronous clear of sticky error flags
- fifo_data_out  output  DATA_W  registered read data
- valid_out  output  1  one-cycle strobe: fifo_data_out holds a newly popped word
- fifo_empty  output  1  count == 0
- fifo_full  output  1  count == DEPTH
- almost_empty  output  1  count ≤ almost_empty_thr
- pausa  output  1  (almost_full_thr != 0) and count ≥ almost_full_thr
- overflow_err  output  1  sticky: push attempted while full without pop
- underflow_err  output  1  sticky: pop attempted while empty
- fifo_error  output  1  overflow_err | underflow_err
- fill_count  output  ADDR_W+1  current occupancy 0..DEPTH

## Operation
- State: DEPTH×DATA_W storage array, write pointer, read pointer (ADDR_W bits, wrap modulo DEPTH), occupancy count, output data register, valid register, two error registers.
- Push accepted when push=1 and (not full, or full and pop accepted the same cycle): write fifo_data_in at wr_ptr, wr_ptr+1.
- Pop accepted when pop=1 and not empty: read entry at rd_ptr into fifo_data_out, rd_ptr+1, valid_out=1 next cycle.
- Count: +1 push only, −1 pop only, unchanged for both or neither.
- Push while full with no pop: word dropped, storage/pointers unchanged, overflow_err set.
- Pop while empty: no read, fifo_data_out holds previous value, valid_out=0, underflow_err set. A simultaneous push on empty is still accepted (no pass-through: word appears only on a later pop).
- Push+pop when full: both accepted, count stays DEPTH, no error.
- Errors stay set until reset or err_clr=1; if err_clr and a new error occur the same cycle, the error wins (flag set).
- Status outputs (empty, full, almost_empty, pausa, fill_count) decode combinationally from registered count and live threshold inputs; thresholds may change at any time and take effect immediately.
- Thresholds above DEPTH are legal: almost_full_thr > DEPTH means pausa never asserts; almost_empty_thr ≥ DEPTH means almost_empty always asserts.

## Timing
- Reset (reset_L=0, asynchronous, immediate): pointers=0, count=0, fifo_data_out=0, valid_out=0, overflow_err=0, underflow_err=0, fifo_error=0; hence fifo_empty=1, fifo_full=0, almost_empty=1, pausa=0 (for thr ≥1), fill_count=0. Storage contents are not cleared and are don't-care.
- Reset asserted mid-operation discards all buffered words; first push after release is the next word read.
- Write latency: word pushed in cycle N is poppable in cycle N+1.
- Read latency: pop accepted at edge N → fifo_data_out and valid_out=1 valid after edge N, i.e. during cycle N+1; valid_out drops after edge N+1 unless another pop is accepted.
- Flags update the cycle after the push/pop edge that changes count.
- Back-to-back pops every cycle produce one word per cycle with valid_out continuously high.

## Test plan
- Reset: hold reset_L=0 → all outputs at reset values above; assert reset mid-stream with count=3 → fill_count=0, fifo_empty=1 immediately, without waiting for a clock edge.
- Fill/drain (DATA_W=6, DEPTH=4, af_thr=3, ae_thr=1): push 0x11,0x16,0x30,0x1C → pausa=1 after 3rd push, fifo_full=1 after 4th; pop ×4 → fifo_data_out 0x11,0x16,0x30,0x1C on consecutive cycles with valid_out=1; almost_empty=1 at count≤1.
- Overflow: full FIFO, push 0x1D alone → overflow_err=1, fifo_error=1, next pops return 0x11.. unchanged; err_clr=1 → errors 0 next cycle.
- Underflow: empty FIFO, pop → underflow_err=1, valid_out=0, fifo_data_out holds last value; pop+push 0x1A on empty → underflow_err=1, count=1, next pop yields 0x1A.
- Simultaneous push/pop: count=1 with push 0x1B+pop, and full with push+pop → count unchanged, no error, data order preserved.
- Wrap/thresholds: 10 interleaved push/pop cycles wrapping pointers ≥2 times → FIFO order intact; change af_thr 3→0 live → pausa deasserts same cycle.

Source files
------------

// File: rtl/fifo_flow_ctrl_if.sv
// Handshake/status bundle between a producer/consumer and fifo_flow_ctrl.
// master drives requests and thresholds; slave (the FIFO) drives data and status.
interface fifo_flow_ctrl_if #(
    parameter int unsigned DATA_W = 6,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic              push;
    logic              pop;
    logic [DATA_W-1:0] fifo_data_in;
    logic [ADDR_W:0]   almost_full_thr;
    logic [ADDR_W:0]   almost_empty_thr;
    logic              err_clr;

    logic [DATA_W-1:0] fifo_data_out;
    logic              valid_out;
    logic              fifo_empty;
    logic              fifo_full;
    logic              almost_empty;
    logic              pausa;
    logic              overflow_err;
    logic              underflow_err;
    logic              fifo_error;
    logic [ADDR_W:0]   fill_count;

    modport master (
        output push, pop, fifo_data_in, almost_full_thr, almost_empty_thr, err_clr,
        input  fifo_data_out, valid_out, fifo_empty, fifo_full, almost_empty, pausa,
               overflow_err, underflow_err, fifo_error, fill_count
    );

    modport slave (
        input  push, pop, fifo_data_in, almost_full_thr, almost_empty_thr, err_clr,
        output fifo_data_out, valid_out, fifo_empty, fifo_full, almost_empty, pausa,
               overflow_err, underflow_err, fifo_error, fill_count
    );
endinterface

// File: rtl/fifo_flow_ctrl.sv
// Synchronous FIFO with registered read port, threshold-based pause toward the
// producer and sticky overflow/underflow flags.
module fifo_flow_ctrl #(
    parameter int unsigned DATA_W = 6,
    parameter int unsigned DEPTH  = 4
) (
    input logic          clk,
    input logic          reset_L,
    fifo_flow_ctrl_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_data_out;
    logic              r_valid;
    logic              r_ovf;
    logic              r_unf;

    logic w_empty;
    logic w_full;
    logic w_pop_acc;
    logic w_push_acc;
    logic w_ovf;
    logic w_unf;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_CNT);
    assign w_pop_acc  = bus.pop && !w_empty;
    // A full FIFO still takes a push when a pop frees a slot in the same cycle.
    assign w_push_acc = bus.push && (!w_full || w_pop_acc);
    assign w_ovf      = bus.push && w_full && !w_pop_acc;
    assign w_unf      = bus.pop && w_empty;

    // Storage is not reset; its contents are unreachable until written.
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= bus.fifo_data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            r_valid <= w_pop_acc;
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop_acc) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
            end
            if (w_push_acc && !w_pop_acc) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop_acc && !w_push_acc) begin
                r_count <= r_count - CNT_W'(1);
            end
            // A fresh error takes priority over a clear in the same cycle.
            if (w_ovf) begin
                r_ovf <= 1'b1;
            end else if (bus.err_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_unf) begin
                r_unf <= 1'b1;
            end else if (bus.err_clr) begin
                r_unf <= 1'b0;
            end
        end
    end

    assign bus.fifo_data_out = r_data_out;
    assign bus.valid_out     = r_valid;
    assign bus.fifo_empty    = w_empty;
    assign bus.fifo_full     = w_full;
    assign bus.almost_empty  = (r_count <= bus.almost_empty_thr);
    assign bus.pausa         = (bus.almost_full_thr != '0) && (r_count >= bus.almost_full_thr);
    assign bus.overflow_err  = r_ovf;
    assign bus.underflow_err = r_unf;
    assign bus.fifo_error    = r_ovf | r_unf;
    assign bus.fill_count    = r_count;
endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Directed bench for fifo_flow_ctrl: expected read words go into a scoreboard
// queue at pop time and a negedge monitor checks every valid_out strobe.
module tb_fifo_flow_ctrl;
    localparam int unsigned DATA_W = 6;
    localparam int unsigned DEPTH  = 4;

    logic clk;
    logic reset_L;

    int total;
    int bad;
    logic [DATA_W-1:0] exp_q[$];

    fifo_flow_ctrl_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    fifo_flow_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every read strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_L && bus.valid_out) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: got valid data %0h expected no strobe",
                         bus.fifo_data_out);
            end else begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                if (bus.fifo_data_out !== e) begin
                    bad++;
                    $display("FAIL rd_data: got %0h expected %0h", bus.fifo_data_out, e);
                end
            end
        end
    end

    // One clock with the given requests; returns 1 time unit after the edge.
    task automatic step(input logic p, input logic q, input logic [DATA_W-1:0] d,
                        input logic ec);
        bus.push         = p;
        bus.pop          = q;
        bus.fifo_data_in = d;
        bus.err_clr      = ec;
        @(posedge clk);
        #1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.err_clr = 1'b0;
    endtask

    task automatic push_w(input logic [DATA_W-1:0] d);
        step(1'b1, 1'b0, d, 1'b0);
    endtask

    task automatic pop_w(input logic [DATA_W-1:0] e);
        exp_q.push_back(e);
        step(1'b0, 1'b1, '0, 1'b0);
    endtask

    task automatic pushpop(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] e);
        exp_q.push_back(e);
        step(1'b1, 1'b1, d, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_L              = 1'b0;
        bus.push             = 1'b0;
        bus.pop              = 1'b0;
        bus.fifo_data_in     = '0;
        bus.err_clr          = 1'b0;
        bus.almost_full_thr  = 3'd3;
        bus.almost_empty_thr = 3'd1;
        #12;
        check("rst_count", 32'(bus.fill_count), 0);
        check("rst_empty", 32'(bus.fifo_empty), 1);
        check("rst_full", 32'(bus.fifo_full), 0);
        check("rst_aempty", 32'(bus.almost_empty), 1);
        check("rst_pausa", 32'(bus.pausa), 0);
        check("rst_valid", 32'(bus.valid_out), 0);
        check("rst_data", 32'(bus.fifo_data_out), 0);
        check("rst_error", 32'({bus.overflow_err, bus.underflow_err, bus.fifo_error}), 0);
        #10;
        reset_L = 1'b1;
        @(posedge clk);
        #1;

        // Fill
        push_w(6'h11);
        check("fill1_count", 32'(bus.fill_count), 1);
        check("fill1_aempty", 32'(bus.almost_empty), 1);
        push_w(6'h16);
        check("fill2_aempty", 32'(bus.almost_empty), 0);
        check("fill2_pausa", 32'(bus.pausa), 0);
        push_w(6'h30);
        check("fill3_pausa", 32'(bus.pausa), 1);
        check("fill3_full", 32'(bus.fifo_full), 0);
        push_w(6'h1C);
        check("fill4_full", 32'(bus.fifo_full), 1);
        check("fill4_count", 32'(bus.fill_count), 4);

        // Overflow and clear
        push_w(6'h1D);
        check("ovf_err", 32'(bus.overflow_err), 1);
        check("ovf_ferr", 32'(bus.fifo_error), 1);
        check("ovf_count", 32'(bus.fill_count), 4);
        step(1'b0, 1'b0, '0, 1'b1);
        check("ovf_clr", 32'({bus.overflow_err, bus.fifo_error}), 0);

        // Drain back-to-back; dropped 0x1D must not appear
        pop_w(6'h11);
        check("drain1_count", 32'(bus.fill_count), 3);
        pop_w(6'h16);
        pop_w(6'h30);
        check("drain3_aempty", 32'(bus.almost_empty), 1);
        check("drain3_valid", 32'(bus.valid_out), 1);
        pop_w(6'h1C);
        check("drain4_empty", 32'(bus.fifo_empty), 1);
        step(1'b0, 1'b0, '0, 1'b0);
        check("idle_valid", 32'(bus.valid_out), 0);

        // Underflow
        step(1'b0, 1'b1, '0, 1'b0);
        check("unf_err", 32'(bus.underflow_err), 1);
        check("unf_valid", 32'(bus.valid_out), 0);
        check("unf_hold", 32'(bus.fifo_data_out), 32'h1C);
        check("unf_count", 32'(bus.fill_count), 0);
        step(1'b1, 1'b1, 6'h1A, 1'b0);
        check("unf_push_count", 32'(bus.fill_count), 1);
        check("unf_push_valid", 32'(bus.valid_out), 0);
        pop_w(6'h1A);
        // Clear and new underflow together: error wins
        step(1'b0, 1'b1, '0, 1'b1);
        check("clr_vs_err", 32'(bus.underflow_err), 1);
        step(1'b0, 1'b0, '0, 1'b1);
        check("unf_clr", 32'({bus.underflow_err, bus.fifo_error}), 0);

        // Simultaneous push/pop at count 1 and at full
        push_w(6'h05);
        pushpop(6'h1B, 6'h05);
        check("pp1_count", 32'(bus.fill_count), 1);
        push_w(6'h21);
        push_w(6'h22);
        push_w(6'h23);
        check("pp_full", 32'(bus.fifo_full), 1);
        pushpop(6'h24, 6'h1B);
        check("ppfull_count", 32'(bus.fill_count), 4);
        check("ppfull_err", 32'(bus.fifo_error), 0);
        pop_w(6'h21);
        pop_w(6'h22);
        pop_w(6'h23);
        pop_w(6'h24);
        check("pp_empty", 32'(bus.fifo_empty), 1);

        // Interleaved traffic wrapping the pointers
        push_w(6'h2A);
        for (int i = 0; i < 10; i++) begin
            pushpop(6'(6'h2B + i), (i == 0) ? 6'h2A : 6'(6'h2A + i));
        end
        check("wrap_count", 32'(bus.fill_count), 1);
        pop_w(6'h34);

        // Live threshold changes
        push_w(6'h01);
        push_w(6'h02);
        push_w(6'h03);
        check("thr_pausa_on", 32'(bus.pausa), 1);
        bus.almost_full_thr = 3'd0;
        #1;
        check("thr_pausa_off", 32'(bus.pausa), 0);
        bus.almost_full_thr = 3'd5;
        bus.almost_empty_thr = 3'd4;
        #1;
        check("thr_above_depth", 32'(bus.pausa), 0);
        check("thr_ae_all", 32'(bus.almost_empty), 1);
        bus.almost_full_thr = 3'd3;
        bus.almost_empty_thr = 3'd1;

        // Mid-stream asynchronous reset with count 3
        #2;
        reset_L = 1'b0;
        #1;
        check("mrst_count", 32'(bus.fill_count), 0);
        check("mrst_empty", 32'(bus.fifo_empty), 1);
        check("mrst_data", 32'(bus.fifo_data_out), 0);
        @(negedge clk);
        reset_L = 1'b1;
        @(posedge clk);
        #1;
        push_w(6'h3F);
        pop_w(6'h3F);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
